// File: rtl/axis_bram_master_ifft.sv
// IFFT output stage: reads FFT_SIZE complex words from BRAM, scales the real part and
// streams four samples per 64-bit AXI-stream beat. Optional feature macro: IFFT_OUT_SATURATE_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 48
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

module axis_bram_master_ifft #(
    parameter int FFT_SIZE     = 4096,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SCALE_SHIFT  = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   axis_bram_master_go,
    output logic                   axis_bram_master_busy,
    output logic                   axis_bram_master_done,
    output logic [`ADDR_WIDTH-1:0] axis_mem2m_raddr,
    output logic                   axis_mem2m_re,
    input  logic [`DATA_WIDTH-1:0] axis_mem2m_rdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [63:0]            m_axis_tdata,
    output logic [7:0]             m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   ifft_sat_seen
);
    localparam int DW = `DATA_WIDTH;
    localparam int HW = DW / 2;
    localparam int AW = `ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [AW-1:0]           raddr_r;
    logic                    rd_valid_r;
    logic [1:0]              rd_lane_r;
    logic                    rd_last_r;
    logic [3*SAMPLE_WIDTH-1:0] pack_r;
    logic [63:0]             fifo_data_r [2];
    logic                    fifo_last_r [2];
    logic                    wr_ptr_r;
    logic                    rd_ptr_r;
    logic [1:0]              fifo_count_r;
    logic                    done_r;
    logic                    sat_r;

    logic                    busy_s;
    logic                    re_s;
    logic                    inflight_s;
    logic                    last_issue_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    head_last_s;
    logic [SAMPLE_WIDTH-1:0] sample_s;
    logic                    sat_hit_s;
    logic                    unused_imag_s;

`ifdef IFFT_OUT_SATURATE_EN
    logic signed [HW-1:0]    scaled_s;

    // The scaled value fits the sample only if all bits above the sample's sign bit match it.
    function automatic logic needs_clamp(input logic signed [HW-1:0] v);
        return !((&v[HW-1:SAMPLE_WIDTH-1]) || !(|v[HW-1:SAMPLE_WIDTH-1]));
    endfunction

    function automatic logic [SAMPLE_WIDTH-1:0] clamp_value(input logic signed [HW-1:0] v);
        return v[HW-1] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}} : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    endfunction
`endif

    assign unused_imag_s = ^axis_mem2m_rdata[HW-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (axis_bram_master_go) state_s = READ;  else state_s = IDLE;
            READ:    if (last_issue_s)        state_s = DRAIN; else state_s = READ;
            DRAIN:   if (pop_s && head_last_s) state_s = IDLE; else state_s = DRAIN;
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs; a read needs room for its beat counting the one possibly in flight.
    always_comb begin
        busy_s = (state_r != IDLE);
        if (state_r == READ) begin
            re_s = (({1'b0, fifo_count_r} + {2'b00, inflight_s}) <= 3'd1);
        end else begin
            re_s = 1'b0;
        end
    end

    // Datapath decode: credit, FIFO handshakes and sample reduction.
    always_comb begin
        inflight_s   = rd_valid_r && (rd_lane_r == 2'd3);
        push_s       = inflight_s;
        last_issue_s = re_s && (raddr_r == AW'(FFT_SIZE - 1));
        pop_s        = (fifo_count_r != 2'd0) && m_axis_tready;
        head_last_s  = fifo_last_r[rd_ptr_r];
`ifdef IFFT_OUT_SATURATE_EN
        scaled_s = $signed(axis_mem2m_rdata[DW-1:HW]) >>> SCALE_SHIFT;
        if (needs_clamp(scaled_s)) begin
            sample_s  = clamp_value(scaled_s);
            sat_hit_s = rd_valid_r;
        end else begin
            sample_s  = scaled_s[SAMPLE_WIDTH-1:0];
            sat_hit_s = 1'b0;
        end
`else
        sample_s  = SAMPLE_WIDTH'($signed(axis_mem2m_rdata[DW-1:HW]) >>> SCALE_SHIFT);
        sat_hit_s = 1'b0;
`endif
    end

    // Read address generation and read-return tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            raddr_r    <= '0;
            rd_valid_r <= 1'b0;
            rd_lane_r  <= 2'd0;
            rd_last_r  <= 1'b0;
        end else begin
            if ((state_r == IDLE) && axis_bram_master_go) begin
                raddr_r <= '0;
            end else if (re_s) begin
                raddr_r <= raddr_r + AW'(1);
            end else begin
                raddr_r <= raddr_r;
            end
            rd_valid_r <= re_s;
            rd_lane_r  <= raddr_r[1:0];
            rd_last_r  <= last_issue_s;
        end
    end

    // Lane packing and the two-entry output FIFO; lane 3 goes straight into the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            pack_r         <= '0;
            fifo_data_r[0] <= 64'd0;
            fifo_data_r[1] <= 64'd0;
            fifo_last_r[0] <= 1'b0;
            fifo_last_r[1] <= 1'b0;
            wr_ptr_r       <= 1'b0;
            rd_ptr_r       <= 1'b0;
            fifo_count_r   <= 2'd0;
        end else begin
            if (rd_valid_r) begin
                case (rd_lane_r)
                    2'd0:    pack_r[SAMPLE_WIDTH-1:0]              <= sample_s;
                    2'd1:    pack_r[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH]   <= sample_s;
                    2'd2:    pack_r[3*SAMPLE_WIDTH-1:2*SAMPLE_WIDTH] <= sample_s;
                    default: pack_r <= pack_r;
                endcase
            end
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= {sample_s, pack_r};
                fifo_last_r[wr_ptr_r] <= rd_last_r;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            fifo_count_r <= fifo_count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Frame-complete pulse and sticky saturation flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_r <= 1'b0;
            sat_r  <= 1'b0;
        end else begin
            done_r <= (state_r == DRAIN) && pop_s && head_last_s;
            if ((state_r == IDLE) && axis_bram_master_go) begin
                sat_r <= 1'b0;
            end else if (sat_hit_s) begin
                sat_r <= 1'b1;
            end else begin
                sat_r <= sat_r;
            end
        end
    end

    assign axis_bram_master_busy = busy_s;
    assign axis_bram_master_done = done_r;
    assign axis_mem2m_raddr      = raddr_r;
    assign axis_mem2m_re         = re_s;
    assign m_axis_tvalid         = (fifo_count_r != 2'd0);
    assign m_axis_tdata          = fifo_data_r[rd_ptr_r];
    assign m_axis_tlast          = fifo_last_r[rd_ptr_r];
    assign m_axis_tkeep          = 8'hFF;
    assign ifft_sat_seen         = sat_r;

endmodule

// File: tb/tb_axis_bram_master_ifft.sv
// Directed bench for axis_bram_master_ifft with a frame-level reference model and
// a per-cycle output comparator (FFT_SIZE=16, SCALE_SHIFT=4).
`ifndef DATA_WIDTH
`define DATA_WIDTH 48
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

module tb_axis_bram_master_ifft;
    localparam int N  = 16;
    localparam int SH = 4;
    localparam int DW = `DATA_WIDTH;
    localparam int HW = DW / 2;
    localparam int AW = `ADDR_WIDTH;
`ifdef IFFT_OUT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic          busy, done, re, tvalid, tlast, sat;
    logic          tready = 1'b1;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata = '0;
    logic [63:0]   tdata;
    logic [7:0]    tkeep;

    axis_bram_master_ifft #(.FFT_SIZE(N), .SAMPLE_WIDTH(16), .SCALE_SHIFT(SH)) dut (
        .clk(clk), .reset(reset),
        .axis_bram_master_go(go), .axis_bram_master_busy(busy), .axis_bram_master_done(done),
        .axis_mem2m_raddr(raddr), .axis_mem2m_re(re), .axis_mem2m_rdata(rdata),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
        .m_axis_tkeep(tkeep), .m_axis_tlast(tlast), .ifft_sat_seen(sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [N];
    always @(posedge clk) if (re) rdata <= mem[raddr[3:0]];

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_data [$];
    bit          exp_last [$];
    bit          exp_sat;
    int          re_cyc [$];
    int          hs_cyc [$];
    logic [63:0] hs_data [$];
    int          tlast_cyc [$];
    int          done_cyc [$];
    int          base = 0;
    bit          mon_en = 0;
    bit          busy_seen = 0;
    int          busy_low = -1;
    bit          stall_prev = 0;
    logic [63:0] held_data;
    logic        held_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int qi(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic logic [63:0] qd(input logic [63:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return '1;
    endfunction

    // Reference: real part, arithmetic scale by 2^SH, then clamp or wrap to 16 bits.
    function automatic logic [15:0] model_sample(input logic [DW-1:0] w, output bit clamped);
        int v;
        v = int'($signed(w[DW-1:HW]));
        v = v >>> SH;
        clamped = 1'b0;
`ifdef IFFT_OUT_SATURATE_EN
        if (v > 32767) begin
            v = 32767;
            clamped = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            clamped = 1'b1;
        end
`endif
        return v[15:0];
    endfunction

    task automatic build_expect();
        logic [63:0] d;
        bit          c;
        exp_data.delete();
        exp_last.delete();
        exp_sat = 1'b0;
        for (int b = 0; b < N / 4; b++) begin
            d = '0;
            for (int l = 0; l < 4; l++) begin
                d[16*l +: 16] = model_sample(mem[4*b + l], c);
                if (c) exp_sat = 1'b1;
            end
            exp_data.push_back(d);
            exp_last.push_back(b == N / 4 - 1);
        end
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < N; k++) mem[k] = {HW'(k * 16), HW'(k * 7 + 3)};
    endtask

    task automatic start_frame();
        mon_en = 1'b0;
        build_expect();
        re_cyc.delete(); hs_cyc.delete(); hs_data.delete(); tlast_cyc.delete(); done_cyc.delete();
        busy_seen = 1'b0;
        busy_low  = -1;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0; base = cyc - 1; mon_en = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cyc.size() == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done_cyc.size() != 0, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_rel(input int r);
        while (cyc - base < r) @(negedge clk);
    endtask

    // Per-cycle comparator: handshakes against the model, hold-while-stalled, event log.
    always begin
        int rel;
        @(negedge clk);
        #1;
        if (!reset && mon_en) begin
            rel = cyc - base;
            if (re) re_cyc.push_back(rel);
            if (done) done_cyc.push_back(rel);
            if (busy) busy_seen = 1'b1;
            else if (busy_seen && busy_low < 0) busy_low = rel;
            if (stall_prev) begin
                check("hold_tvalid", tvalid, 1'b1);
                check("hold_tdata", tdata, held_data);
                check("hold_tlast", tlast, held_last);
            end
            if (tvalid) begin
                check("tkeep", tkeep, 8'hFF);
                if (tready) begin
                    if (exp_data.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got tdata 0x%0h, want no beat", tdata);
                    end else begin
                        check("tdata", tdata, exp_data.pop_front());
                        check("tlast", tlast, exp_last.pop_front());
                    end
                    hs_cyc.push_back(rel);
                    hs_data.push_back(tdata);
                    if (tlast) tlast_cyc.push_back(rel);
                end
            end
            stall_prev = tvalid && !tready;
            held_data  = tdata;
            held_last  = tlast;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1);
    end

    initial begin
        int n;
        fill_ramp();
        repeat (3) @(negedge clk);
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tdata", tdata, 64'd0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_re", re, 1'b0);
        check("rst_raddr", raddr, '0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sat", sat, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Ramp frame, tready high.
        tready = 1'b1;
        start_frame();
        wait_done(60);
        check("ramp_re_count", re_cyc.size(), 16);
        check("ramp_re_first", qi(re_cyc, 0), 1);
        check("ramp_re_last", qi(re_cyc, 15), 16);
        for (int i = 0; i < 4; i++) check("ramp_beat_cycle", qi(hs_cyc, i), 6 + 4 * i);
        check("ramp_beat0", qd(hs_data, 0), 64'h0003_0002_0001_0000);
        check("ramp_beat3", qd(hs_data, 3), 64'h000F_000E_000D_000C);
        check("ramp_tlast_count", tlast_cyc.size(), 1);
        check("ramp_tlast_cycle", qi(tlast_cyc, 0), 18);
        check("ramp_done_count", done_cyc.size(), 1);
        check("ramp_done_cycle", qi(done_cyc, 0), 19);
        check("ramp_busy_low", busy_low, 19);

        // Backpressure: tready low for 12 cycles from first tvalid.
        tready = 1'b0;
        start_frame();
        wait_rel(12);
        check("bp_re_stalled", re, 1'b0);
        wait_rel(18);
        tready = 1'b1;
        n = 0;
        foreach (re_cyc[i]) if (re_cyc[i] < 18) n++;
        check("bp_reads_before_release", n, 8);
        wait_done(80);
        check("bp_beats", hs_cyc.size(), 4);
        check("bp_tlast_count", tlast_cyc.size(), 1);
        check("bp_first_beat_cycle", qi(hs_cyc, 0), 18);
        check("bp_beat0", qd(hs_data, 0), 64'h0003_0002_0001_0000);
        check("bp_model_drained", exp_data.size(), 0);

        // Saturation inputs in lanes 0 and 1 of beat 1.
        mem[4] = {24'h7FFFF0, 24'h000001};
        mem[5] = {24'hF00000, 24'h000123};
        start_frame();
        wait_done(60);
        check("sat_lane0", qd(hs_data, 1) & 64'hFFFF, SAT ? 64'h7FFF : 64'hFFFF);
        check("sat_lane1", (qd(hs_data, 1) >> 16) & 64'hFFFF, SAT ? 64'h8000 : 64'h0000);
        check("sat_flag_literal", sat, SAT);
        check("sat_flag_model", sat, exp_sat);

        // Reset one cycle after the beat-1 handshake.
        fill_ramp();
        tready = 1'b1;
        start_frame();
        n = 0;
        while (hs_cyc.size() < 2 && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("mid_beat1_seen", hs_cyc.size(), 2);
        @(negedge clk);
        reset = 1'b1;
        exp_data.delete();
        exp_last.delete();
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("mid_tvalid", tvalid, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_re", re, 1'b0);
        repeat (20) @(negedge clk);
        check("mid_no_more_beats", hs_cyc.size(), 2);
        check("mid_no_tlast", tlast_cyc.size(), 0);
        start_frame();
        check("restart_raddr", raddr, '0);
        check("restart_re", re, 1'b1);
        wait_done(60);
        check("restart_beat0", qd(hs_data, 0), 64'h0003_0002_0001_0000);
        check("restart_beats", hs_cyc.size(), 4);

        // go pulses while busy are ignored; sticky flag survives until the next idle go.
        mem[5] = {24'h7FFFF0, 24'h000000};
        start_frame();
        wait_rel(3);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_rel(12);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done(60);
        repeat (10) @(negedge clk);
        check("busy_go_done_count", done_cyc.size(), 1);
        check("busy_go_beats", hs_cyc.size(), 4);
        check("busy_go_idle", busy, 1'b0);
        check("sticky_after_frame", sat, SAT);
        start_frame();
        check("sticky_cleared_by_go", sat, 1'b0);
        wait_done(60);
        check("sticky_model", sat, exp_sat);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axis_bram_master_ifft.md
# axis_bram_master_ifft

Output stage of the inverse-FFT path: once the in-place IFFT finishes, reads the FFT_SIZE complex result words from the FFT working BRAM in natural order. It keeps only the real part, applies a fixed arithmetic right shift, and reduces each result to a SAMPLE_WIDTH sample. Four samples are packed per 64-bit beat and sent on an AXI-stream master toward the DMA. It is the read-side counterpart of the half-spectrum BRAM writer that feeds the IFFT.

## Interface
- FFT_SIZE, 4096: number of words read per frame; power of two, at least 4.
- SAMPLE_WIDTH, 16: output sample width; fixed at 64/4.
- SCALE_SHIFT, 12: arithmetic right shift applied to the real part (IFFT 1/N normalisation).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- axis_bram_master_go  in  1  start pulse; sampled only in IDLE.
- axis_bram_master_busy  out  1  high whenever state != IDLE.
- axis_bram_master_done  out  1  one-cycle pulse when a frame completes.
- axis_mem2m_raddr  out  `ADDR_WIDTH  BRAM read address.
- axis_mem2m_re  out  1  BRAM read enable.
- axis_mem2m_rdata  in  `DATA_WIDTH  read data, valid 1 cycle after re. Word layout: {real[`DATA_WIDTH-1:`DATA_WIDTH/2], imag[`DATA_WIDTH/2-1:0]}, both signed.
- m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tdata  out  64; m_axis_tkeep  out  8; m_axis_tlast  out  1.
- ifft_sat_seen  out  1  sticky saturation flag; cleared by go or reset.

## Operation
- States: IDLE, READ, DRAIN.
  - IDLE -> READ on go; address counter cleared.
  - READ -> DRAIN in the cycle the read of address FFT_SIZE-1 is issued.
  - DRAIN -> IDLE in the cycle after the handshake of the tlast beat; done pulses in that IDLE cycle.
- go while busy: ignored.
- Read issue: re=1 in READ iff fifo_count + inflight_beat <= 1.
  - inflight_beat = 1 when the previous cycle issued an address with addr[1:0]==3.
  - raddr increments by 1 per issued read.
- Sample path, in the cycle rdata is valid:
  - s = real >>> SCALE_SHIFT.
  - s is reduced to SAMPLE_WIDTH (see Configuration).
  - s is written to lane addr[1:0] of the pack register; lane k occupies tdata[16k+15:16k], lane 0 = lowest address.
- When lane 3 is written, the full beat is pushed into a 2-entry output FIFO. tlast is tagged on beat FFT_SIZE/4-1.
- Output: tvalid = FIFO not empty. tdata/tlast come from the FIFO head. A beat is popped on tvalid&tready.
- tdata/tlast hold stable while tvalid&!tready.
- tkeep is constant 8'hFF.
- Imaginary part is discarded.

## Timing
- Reset values: state IDLE, tvalid 0, tdata 0, tlast 0, re 0, raddr 0, done 0, busy 0, ifft_sat_seen 0, FIFO empty, pack register 0.
- Reset mid-frame: all state cleared on the next edge; no further beats and no tlast are emitted. A later go restarts from address 0.
- go sampled at cycle 0: READ from cycle 1; first re at cycle 1; first rdata at cycle 2.
- Beat 0 is pushed at the end of cycle 5; first tvalid at cycle 6.
- With tready held high: one read per cycle, one beat per 4 cycles, no stalls.
- The FIFO never overflows; the credit rule guarantees this under any tready pattern.

## Configuration
- IFFT_OUT_SATURATE_EN defined:
  - s is clamped to [-32768, 32767].
  - Any clamp sets ifft_sat_seen until the next go or reset.
- IFFT_OUT_SATURATE_EN undefined:
  - s is truncated to its low SAMPLE_WIDTH bits (wraps).
  - ifft_sat_seen is tied 0.

## Test plan
Bench parameters: FFT_SIZE=16, `DATA_WIDTH=48, SCALE_SHIFT=4.
- Ramp, real at address k = k<<4, tready=1, go at cycle 0:
  - re high cycles 1-16.
  - Beats at cycles 6/10/14/18: beat0 tdata=0x0003_0002_0001_0000, beat3 tdata=0x000F_000E_000D_000C.
  - tlast only at cycle 18; done at cycle 19; busy low from cycle 19.
- Backpressure: tready=0 for 12 cycles from the first tvalid.
  - tdata stays stable while stalled.
  - re stops once FIFO holds 2 beats plus no in-flight beat.
  - After release, all 4 beats arrive in order with correct data and a single tlast.
- Saturation, with macro: real=0x7FFFF0 gives 0x7FFF and sets ifft_sat_seen; real=-0x100000 gives 0x8000.
- Saturation, without macro: the same inputs give 0xFFFF and 0x0000; ifft_sat_seen stays 0.
- Reset mid-frame, asserted one cycle after the beat-1 handshake:
  - Next cycle: tvalid=0, busy=0, re=0.
  - A new go restarts at raddr=0 and produces beat0 of the ramp again.
- go during busy:
  - go pulses at cycles 3 and 12 are ignored; exactly one frame and one done pulse result.
  - A ifft_sat_seen flag set during the frame is cleared only by the next go in IDLE.
